parallel_to_serial_cmd: RTL and testbench
=========================================

PARALLEL_TO_SERIAL_CMD -- requirements
Module: parallel_to_serial_cmd

Interface
REQ-001 SHALL provide parameter WIDTH, default 48: parallel frame width in bits (SD command frame).
REQ-002 SHALL provide parameter FRAME_SIZE_WIDTH, default 8: width of the framesize bit-count input.
REQ-003 SHALL provide port Clock, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL provide port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL provide port Enable, input, 1: shift qualifier; low pauses transmission.
REQ-006 SHALL provide port Load, input, 1: single-cycle request to start a frame.
REQ-007 SHALL provide port parallel, input, WIDTH: frame word, transmitted MSB first.
REQ-008 SHALL provide port framesize, input, FRAME_SIZE_WIDTH: number of bits to transmit.
REQ-009 SHALL provide port serial, output, 1: registered CMD line data.
REQ-010 SHALL provide port serialEnable, output, 1: line drive enable; low means the line is released (high-Z at pad).
REQ-011 SHALL provide port busy, output, 1: high from accepted Load until complete.
REQ-012 SHALL provide port complete, output, 1: one-cycle pulse after the last bit.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE: serial=1, serialEnable=0, busy=0, complete=0.
REQ-015 Load=1 in IDLE SHALL capture parallel and framesize and enter SHIFT the next cycle, regardless of Enable.
REQ-016 Load in SHIFT or DONE SHALL be ignored; the captured word SHALL NOT change.
REQ-017 SHIFT: serialEnable=1, busy=1, serial = current MSB of the shift register.
REQ-018 First bit (parallel[WIDTH-1]) SHALL appear on serial the cycle after Load; with Enable held high, bit k appears k cycles later.
REQ-019 Each SHIFT cycle with Enable=1 SHALL shift left by one (filling with 1) and increment the bit counter.
REQ-020 Enable=0 in SHIFT SHALL hold serial, shift register and counter unchanged; serialEnable stays 1.
REQ-021 When the counter reaches the captured framesize, the FSM SHALL enter DONE; serial=1, serialEnable=0, complete=1 for exactly one cycle, then IDLE.
REQ-022 framesize=0 SHALL go IDLE->DONE directly (no bits driven, serialEnable never high), complete one cycle after Load.
REQ-023 framesize>WIDTH SHALL transmit WIDTH data bits followed by 1s until the count is reached.
REQ-024 Load in the DONE cycle SHALL be ignored; a new frame needs Load in IDLE.
REQ-025 Counter SHALL be FRAME_SIZE_WIDTH bits, cleared on Load acceptance and in DONE; no wrap is reachable.

Reset
REQ-026 Reset low SHALL asynchronously force IDLE, serial=1, serialEnable=0, busy=0, complete=0, counter=0, shift register all 1s.
REQ-027 Reset mid-frame SHALL abort the frame with no complete pulse; operation resumes on the first Clock edge after Reset rises.

Structure
REQ-028 FSM state encoding, the default CMD frame width (48) and the line idle level (1) SHALL live in a shared package.
REQ-029 The bit counter SHALL be the codebase's existing UPCOUNTER_POSEDGE instance; no other sub-module.

Verification
REQ-030 Load parallel=48'hA5_0000_0000_01, framesize=48, Enable=1 -> serial shows 1,0,1,0,0,1,0,1... over 48 cycles starting the cycle after Load; complete one cycle later.
REQ-031 Same frame, Enable low for 3 cycles after bit 10 -> bit 10 held 3 extra cycles, total frame 51 cycles, serialEnable high throughout.
REQ-032 framesize=0 with Load -> complete the next cycle; serialEnable stays 0.
REQ-033 framesize=8 on WIDTH=48, parallel MSB byte 8'h3C -> 0,0,1,1,1,1,0,0 then complete; remaining bits never driven.
REQ-034 Second Load at bit 5 with different data -> ignored; first frame completes unchanged.
REQ-035 Reset low at bit 20 -> serialEnable=0, serial=1 immediately (asynchronously); no complete; a fresh Load after release transmits correctly.

Source files
------------

// File: rtl/parallel_to_serial_cmd_pkg.sv
// Shared definitions for the SD CMD-line parallel-to-serial transmitter:
// FSM encoding, default command frame width and the released-line level.
package parallel_to_serial_cmd_pkg;

    localparam int   CMD_FRAME_WIDTH = 48;
    localparam logic LINE_IDLE       = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // A state that drives data onto the CMD line.
    function automatic logic drives_line(input state_e st);
        return (st == ST_SHIFT) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/parallel_to_serial_cmd_upcounter.sv
// Generic rising-edge up-counter with synchronous load of an initial value.
module UPCOUNTER_POSEDGE #(
    parameter int SIZE = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Initialize,
    input  logic            Enable,
    input  logic [SIZE-1:0] Initial,
    output logic [SIZE-1:0] Counter
);

    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] count_d;

    // Next count: load has priority over increment.
    always_comb begin
        count_d = count_q;
        if (Initialize) begin
            count_d = Initial;
        end else if (Enable) begin
            count_d = count_q + {{(SIZE-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= {SIZE{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign Counter = count_q;

endmodule

// File: rtl/parallel_to_serial_cmd.sv
// SD CMD-line transmitter: captures a frame on Load and shifts it out MSB
// first, qualified by Enable, then pulses complete for one cycle.
module parallel_to_serial_cmd
    import parallel_to_serial_cmd_pkg::*;
#(
    parameter int WIDTH            = CMD_FRAME_WIDTH,
    parameter int FRAME_SIZE_WIDTH = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        Enable,
    input  logic                        Load,
    input  logic [WIDTH-1:0]            parallel,
    input  logic [FRAME_SIZE_WIDTH-1:0] framesize,
    output logic                        serial,
    output logic                        serialEnable,
    output logic                        busy,
    output logic                        complete
);

    state_e                      state_q, state_d;
    logic [WIDTH-1:0]            shreg_q, shreg_d;
    logic [FRAME_SIZE_WIDTH-1:0] fsize_q, fsize_d;
    logic [FRAME_SIZE_WIDTH-1:0] count_s;
    logic [FRAME_SIZE_WIDTH:0]   count_next_s;
    logic                        cnt_clear_s;
    logic                        cnt_inc_s;
    logic                        serial_q, serial_d;
    logic                        sen_q, sen_d;
    logic                        busy_q, busy_d;
    logic                        cpl_q, cpl_d;

    UPCOUNTER_POSEDGE #(
        .SIZE (FRAME_SIZE_WIDTH)
    ) u_bit_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .Initialize (cnt_clear_s),
        .Enable     (cnt_inc_s),
        .Initial    ({FRAME_SIZE_WIDTH{1'b0}}),
        .Counter    (count_s)
    );

    // One bit wider so the compare cannot wrap at the top framesize.
    assign count_next_s = {1'b0, count_s} + {{FRAME_SIZE_WIDTH{1'b0}}, 1'b1};

    // Next-state, shift register, captured framesize and counter control.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        fsize_d     = fsize_q;
        cnt_clear_s = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Load) begin
                    shreg_d     = parallel;
                    fsize_d     = framesize;
                    cnt_clear_s = 1'b1;
                    if (framesize == {FRAME_SIZE_WIDTH{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (Enable) begin
                    shreg_d   = {shreg_q[WIDTH-2:0], LINE_IDLE};
                    cnt_inc_s = 1'b1;
                    if (count_next_s == {1'b0, fsize_q}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                shreg_d     = {WIDTH{LINE_IDLE}};
                cnt_clear_s = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                shreg_d     = {WIDTH{LINE_IDLE}};
                cnt_clear_s = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        serial_d = LINE_IDLE;
        sen_d    = 1'b0;
        busy_d   = 1'b0;
        cpl_d    = 1'b0;
        case (state_d)
            ST_SHIFT: begin
                serial_d = shreg_d[WIDTH-1];
                sen_d    = drives_line(state_d);
                busy_d   = 1'b1;
            end
            ST_DONE: begin
                busy_d = 1'b1;
                cpl_d  = 1'b1;
            end
            default: begin
                serial_d = LINE_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= {WIDTH{LINE_IDLE}};
            fsize_q  <= {FRAME_SIZE_WIDTH{1'b0}};
            serial_q <= LINE_IDLE;
            sen_q    <= 1'b0;
            busy_q   <= 1'b0;
            cpl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            fsize_q  <= fsize_d;
            serial_q <= serial_d;
            sen_q    <= sen_d;
            busy_q   <= busy_d;
            cpl_q    <= cpl_d;
        end
    end

    assign serial       = serial_q;
    assign serialEnable = sen_q;
    assign busy         = busy_q;
    assign complete     = cpl_q;

endmodule

// File: tb/tb_parallel_to_serial_cmd.sv
// Directed self-checking bench for parallel_to_serial_cmd (WIDTH=48, 8-bit framesize).
module tb_parallel_to_serial_cmd;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Load;
    logic [47:0] parallel;
    logic [7:0]  framesize;
    logic        serial;
    logic        serialEnable;
    logic        busy;
    logic        complete;

    int pass_cnt  = 0;
    int total_cnt = 0;

    parallel_to_serial_cmd #(
        .WIDTH            (48),
        .FRAME_SIZE_WIDTH (8)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Enable       (Enable),
        .Load         (Load),
        .parallel     (parallel),
        .framesize    (framesize),
        .serial       (serial),
        .serialEnable (serialEnable),
        .busy         (busy),
        .complete     (complete)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int idx);
        chk({tag, "_serial"}, idx, {15'd0, serial}, 16'd1);
        chk({tag, "_sen"}, idx, {15'd0, serialEnable}, 16'd0);
        chk({tag, "_busy"}, idx, {15'd0, busy}, 16'd0);
        chk({tag, "_cpl"}, idx, {15'd0, complete}, 16'd0);
    endtask

    // Called on a negedge; drives Load, then checks every bit of the frame,
    // the completion cycle and that a Load during DONE is ignored.
    task automatic run_frame(input string tag, input logic [47:0] data, input logic [7:0] fs,
                             input int pause_bit, input int pause_len, input int reload_bit);
        int   bit_idx;
        int   held;
        int   cycles;
        bit   reloaded;
        logic exp_bit;
        bit_idx   = 0;
        held      = 0;
        cycles    = 0;
        reloaded  = 1'b0;
        parallel  = data;
        framesize = fs;
        Enable    = 1'b1;
        Load      = 1'b1;
        @(negedge Clock);
        Load = 1'b0;
        while (bit_idx < int'(fs)) begin
            exp_bit = (bit_idx < 48) ? data[47 - bit_idx] : 1'b1;
            chk({tag, "_bit"}, bit_idx, {15'd0, serial}, {15'd0, exp_bit});
            chk({tag, "_sen"}, bit_idx, {15'd0, serialEnable}, 16'd1);
            chk({tag, "_busy"}, bit_idx, {15'd0, busy}, 16'd1);
            chk({tag, "_cpl_early"}, bit_idx, {15'd0, complete}, 16'd0);
            if (bit_idx == reload_bit && !reloaded) begin
                Load      = 1'b1;
                parallel  = ~data;
                framesize = 8'd3;
                reloaded  = 1'b1;
            end else begin
                Load = 1'b0;
            end
            if (bit_idx == pause_bit && held < pause_len) begin
                Enable = 1'b0;
                held++;
            end else begin
                Enable = 1'b1;
                bit_idx++;
            end
            cycles++;
            @(negedge Clock);
        end
        Load = 1'b0;
        chk({tag, "_frame_cycles"}, 0, cycles[15:0], fs + pause_len[15:0]);
        chk({tag, "_done_cpl"}, 0, {15'd0, complete}, 16'd1);
        chk({tag, "_done_sen"}, 0, {15'd0, serialEnable}, 16'd0);
        chk({tag, "_done_serial"}, 0, {15'd0, serial}, 16'd1);
        // Load during DONE must not start a frame.
        parallel  = data;
        framesize = 8'd8;
        Load      = 1'b1;
        @(negedge Clock);
        Load = 1'b0;
        chk_idle({tag, "_after"}, 0);
        @(negedge Clock);
        chk_idle({tag, "_after"}, 1);
    endtask

    initial begin
        Reset     = 1'b0;
        Enable    = 1'b0;
        Load      = 1'b0;
        parallel  = 48'd0;
        framesize = 8'd0;
        repeat (2) @(negedge Clock);
        chk_idle("reset", 0);
        Reset = 1'b1;
        @(negedge Clock);
        chk_idle("post_reset", 0);

        // Full 48-bit frame; first byte 8'hA5 = 1,0,1,0,0,1,0,1, last bit 1.
        run_frame("full48", 48'hA5_0000_0000_01, 8'd48, -1, 0, -1);

        // Enable low for 3 cycles while bit 10 is on the line.
        run_frame("pause", 48'hA5_0000_0000_01, 8'd48, 10, 3, -1);

        // Zero-length frame: straight to complete, line never driven.
        run_frame("fs0", 48'hFFFF_FFFF_FFFF, 8'd0, -1, 0, -1);

        // Short frame: only the MSB byte 8'h3C goes out.
        run_frame("fs8", 48'h3C_0000_0000_00, 8'd8, -1, 0, -1);

        // Second Load at bit 5 is ignored.
        run_frame("reload", 48'hA5_0000_0000_01, 8'd48, -1, 0, 5);

        // framesize beyond WIDTH: 48 data bits then trailing 1s.
        run_frame("fs50", 48'h0000_0000_0000, 8'd50, -1, 0, -1);

        // Reset asserted while bit 20 is on the line.
        parallel  = 48'h0000_0000_0000;
        framesize = 8'd48;
        Enable    = 1'b1;
        Load      = 1'b1;
        @(negedge Clock);
        Load = 1'b0;
        repeat (20) @(negedge Clock);
        chk("rst_mid_sen_before", 0, {15'd0, serialEnable}, 16'd1);
        chk("rst_mid_serial_before", 0, {15'd0, serial}, 16'd0);
        #2 Reset = 1'b0;
        #1;
        chk_idle("rst_async", 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            chk_idle("rst_hold", i);
        end
        Reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock);
            chk_idle("rst_released", i);
        end
        run_frame("after_rst", 48'h3C_0000_0000_00, 8'd8, -1, 0, -1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
